// File: rtl/ca_pkg.sv
// Shared types and constants for the cellular-automaton row scheduler.
package ca_pkg;

    localparam int CA_COORD_W = 10;

    localparam logic [7:0] CA_DEFAULT_RULE = 8'd30;

    typedef enum logic [1:0] {
        CA_INIT  = 2'd0,
        CA_ALIGN = 2'd1,
        CA_RUN   = 2'd2
    } ca_state_t;

endpackage

// File: rtl/ca_row_scheduler_if.sv
// Pixel-coordinate, rule-handshake and cell-output bundle of ca_row_scheduler.
interface ca_row_scheduler_if;
    import ca_pkg::*;

    logic [CA_COORD_W-1:0] x_pixel_coord_i;
    logic [CA_COORD_W-1:0] y_pixel_coord_i;
    logic [7:0]            rule_i;
    logic                  rule_valid_i;
    logic                  rule_ready_o;
    logic                  cell_o;
    logic                  frame_start_o;
    logic [7:0]            active_rule_o;
    logic [1:0]            state_o;

    modport master (
        output x_pixel_coord_i, y_pixel_coord_i, rule_i, rule_valid_i,
        input  rule_ready_o, cell_o, frame_start_o, active_rule_o, state_o
    );

    modport slave (
        input  x_pixel_coord_i, y_pixel_coord_i, rule_i, rule_valid_i,
        output rule_ready_o, cell_o, frame_start_o, active_rule_o, state_o
    );

endinterface

// File: rtl/ca_rule_lookup.sv
// Elementary CA update: the rule bit selected by the {left, centre, right} neighbourhood.
module ca_rule_lookup (
    input  logic [2:0] nbhd_i,
    input  logic [7:0] rule_i,
    output logic       cell_o
);

    assign cell_o = rule_i[nbhd_i];

endmodule

// File: rtl/ca_row_scheduler.sv
// Ping-pong row buffers stepping a 1-D CA in lock-step with the pixel scan.
// Optional macro CA_WRAP_EDGES_EN: toroidal neighbours at the row edges.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// CA_INIT  | one cycle after reset: seed read buffer, clear write buffer
// CA_ALIGN | output 0, wait for the last pixel of a frame
// CA_RUN   | display read row, compute next generation into write row
module ca_row_scheduler
    import ca_pkg::*;
#(
    parameter int         H_ACTIVE     = 640,
    parameter int         V_ACTIVE     = 480,
    parameter int         SEED_X       = 320,
    parameter logic [7:0] DEFAULT_RULE = CA_DEFAULT_RULE
) (
    input  logic                clock_i,
    input  logic                reset_i,
    ca_row_scheduler_if.slave   bus
);

    localparam logic [H_ACTIVE-1:0]   SEED_ROW = {{(H_ACTIVE-1){1'b0}}, 1'b1} << SEED_X;
    localparam logic [CA_COORD_W-1:0] X_LAST   = CA_COORD_W'(H_ACTIVE - 1);
    localparam logic [CA_COORD_W-1:0] Y_LAST   = CA_COORD_W'(V_ACTIVE - 1);

    ca_state_t             state_q, state_d;
    logic [H_ACTIVE-1:0]   buf_a_q, buf_a_d;
    logic [H_ACTIVE-1:0]   buf_b_q, buf_b_d;
    logic                  sel_q, sel_d;
    logic                  cell_q, cell_d;
    logic                  frame_start_q, frame_start_d;
    logic [7:0]            active_rule_q, active_rule_d;
    logic [7:0]            pend_rule_q, pend_rule_d;
    logic                  pend_v_q, pend_v_d;

    logic [CA_COORD_W-1:0] x, y, xi, xl, xr;
    logic                  in_range, line_end, frame_end, boundary, accept;
    logic [H_ACTIVE-1:0]   read_row;
    logic                  left, centre, right, next_cell;

    assign x         = bus.x_pixel_coord_i;
    assign y         = bus.y_pixel_coord_i;
    assign in_range  = (x <= X_LAST) && (y <= Y_LAST);
    assign line_end  = (x == X_LAST);
    assign frame_end = line_end && (y == Y_LAST);
    assign xi        = in_range ? x : '0;
    assign xl        = xi - 1'b1;
    assign xr        = xi + 1'b1;

    // sel_q = 0: buffer A is displayed, buffer B receives the next generation
    assign read_row = sel_q ? buf_b_q : buf_a_q;
    assign centre   = read_row[xi];

`ifdef CA_WRAP_EDGES_EN
    assign left  = (xi == '0)     ? read_row[H_ACTIVE-1] : read_row[xl];
    assign right = (xi == X_LAST) ? read_row[0]          : read_row[xr];
`else
    assign left  = (xi == '0)     ? 1'b0 : read_row[xl];
    assign right = (xi == X_LAST) ? 1'b0 : read_row[xr];
`endif

    ca_rule_lookup u_rule_lookup (
        .nbhd_i ({left, centre, right}),
        .rule_i (active_rule_q),
        .cell_o (next_cell)
    );

    assign bus.rule_ready_o  = (state_q != CA_INIT) && !pend_v_q;
    assign accept            = bus.rule_valid_i && bus.rule_ready_o;
    assign bus.cell_o        = cell_q;
    assign bus.frame_start_o = frame_start_q;
    assign bus.active_rule_o = active_rule_q;
    assign bus.state_o       = state_q;

    always_comb begin
        state_d       = state_q;
        buf_a_d       = buf_a_q;
        buf_b_d       = buf_b_q;
        sel_d         = sel_q;
        cell_d        = 1'b0;
        frame_start_d = 1'b0;
        active_rule_d = active_rule_q;
        pend_rule_d   = pend_rule_q;
        pend_v_d      = pend_v_q;
        boundary      = 1'b0;

        case (state_q)
            CA_INIT: begin
                buf_a_d = SEED_ROW;
                buf_b_d = '0;
                sel_d   = 1'b0;
                state_d = CA_ALIGN;
            end
            CA_ALIGN: begin
                // Entering RUN is itself a frame boundary, so row 0 is the seed
                if (frame_end) begin
                    boundary = 1'b1;
                    state_d  = CA_RUN;
                    if (sel_q) buf_b_d = SEED_ROW;
                    else       buf_a_d = SEED_ROW;
                end
            end
            CA_RUN: begin
                if (!in_range) begin
                    state_d = CA_ALIGN;
                end else begin
                    cell_d        = centre;
                    frame_start_d = (x == '0) && (y == '0);
                    if (sel_q) buf_a_d[xi] = next_cell;
                    else       buf_b_d[xi] = next_cell;
                    if (frame_end) begin
                        boundary = 1'b1;
                        if (sel_q) buf_b_d = SEED_ROW;
                        else       buf_a_d = SEED_ROW;
                    end else if (line_end) begin
                        sel_d = ~sel_q;
                    end
                end
            end
            default: state_d = CA_INIT;
        endcase

        // accept only happens with the slot empty, so it never collides with a swap
        if (boundary && pend_v_q) begin
            active_rule_d = pend_rule_q;
            pend_v_d      = 1'b0;
        end
        if (accept) begin
            pend_rule_d = bus.rule_i;
            pend_v_d    = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q       <= CA_INIT;
            buf_a_q       <= '0;
            buf_b_q       <= '0;
            sel_q         <= 1'b0;
            cell_q        <= 1'b0;
            frame_start_q <= 1'b0;
            active_rule_q <= DEFAULT_RULE;
            pend_rule_q   <= '0;
            pend_v_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            buf_a_q       <= buf_a_d;
            buf_b_q       <= buf_b_d;
            sel_q         <= sel_d;
            cell_q        <= cell_d;
            frame_start_q <= frame_start_d;
            active_rule_q <= active_rule_d;
            pend_rule_q   <= pend_rule_d;
            pend_v_q      <= pend_v_d;
        end
    end

endmodule
